var_unshift_tx: RTL and testbench
=================================

Name: var_unshift_tx

Overview:
- Transmit-side counterpart of the team's variable shift-in register.
- Accepts one parallel 32-bit word plus a direction and a chunk size, then emits the word as a sequence of variable-width chunks over a valid/ready stream.
- A downstream variable shift-in register reassembles the word from those chunks.
- Sits between a word producer and a serial/narrow link.

Parameters:
- WIDTH, 32, data word width in bits.
- SHW, 6, width of chunk-size and bit-count fields (holds 0..WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset; asynchronous, active-high.
- load_valid  input  1  producer presents a word.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialise.
- load_dir  input  1  0 = right shift (LSB chunk first); 1 = left shift (MSB chunk first).
- load_shift  input  SHW  bits per beat; 0 or >WIDTH is treated as WIDTH.
- out_valid  output  1  chunk available.
- out_ready  input  1  consumer accepts chunk.
- out_data  output  WIDTH  chunk, right-justified; bits above out_bits are 0.
- out_bits  output  SHW  number of valid bits in out_data (1..WIDTH).
- out_last  output  1  current beat is the final chunk of the word.

Behaviour:
- Reset (clr=1, asynchronous) forces:
  - state=IDLE, out_valid=0, out_data=0, out_bits=0, out_last=0.
  - Internal shift register, remaining-bit count, dir and size registers all cleared.
  - load_ready=1 while in IDLE and not in reset.
- Reset mid-word aborts the word; no further beats of it are emitted.
- States:
  - IDLE: load_ready=1, out_valid=0.
  - SEND: out_valid=1.
- Load: load_valid & load_ready.
  - Captures load_data into sreg and load_dir into dreg.
  - Captures the clamped load_shift into nreg.
  - Sets rem=WIDTH and enters SEND.
  - First beat is valid on the next cycle (1-cycle latency).
- In SEND, each beat is registered and stable while out_valid & !out_ready:
  - k = min(nreg, rem).
  - out_bits = k.
  - out_last = (rem == k).
  - dir=0: out_data = sreg[k-1:0] zero-extended.
  - dir=1: out_data = sreg[WIDTH-1:WIDTH-k] right-justified.
- Beat handshake: out_valid & out_ready.
  - rem -= k.
  - dir=0: sreg >>= k. dir=1: sreg <<= k. Zero-fill in both cases.
  - If out_last, go to IDLE; otherwise stay in SEND.
- Beats per word = ceil(WIDTH/n). Only the final beat may be short (WIDTH mod n bits).
- Back-to-back:
  - load_ready = IDLE | (out_valid & out_last & out_ready).
  - A load in the same cycle as the last handshake goes directly to SEND with the new word.
  - No idle bubble between words.
- load_* inputs are ignored when load_ready=0.
- dir and size are frozen per word.
- out_ready asserted while out_valid=0 has no effect.
- All arithmetic is unsigned, SHW bits. rem never underflows because k <= rem.

Decomposition:
- Shared package var_shift_pkg holds:
  - WIDTH and SHW defaults.
  - DIR_RIGHT=0 and DIR_LEFT=1 constants.
  - State enum {IDLE, SEND}.
  - The clamp rule (0 or >WIDTH maps to WIDTH) as a function, reused by the shift-in receiver.
- One sub-module is natural: var_chunk_sel.
  - Combinational.
  - Inputs: sreg, dir, k.
  - Output: the right-justified out_data.
- Registers and the FSM stay in the top module.

Test Plan:
1. Right-shift, bytes: load 0xA1B2C3D4, dir=0, shift=8, out_ready=1.
   - Expect 4 beats: 0xD4, 0xC3, 0xB2, 0xA1, each with out_bits=8.
   - out_last on the 4th beat, then IDLE.
2. Left-shift, bytes: same word, dir=1, shift=8.
   - Expect 0xA1, 0xB2, 0xC3, 0xD4, with out_last on the 4th beat.
3. Short final beat: load 0xFFFFFFFF, dir=0, shift=6.
   - Expect 5 beats of out_data=0x3F with out_bits=6.
   - Then a 6th beat of out_data=0x3 with out_bits=2 and out_last=1.
4. Clamp: shift=0 and shift=40, word 0x12345678.
   - Each gives a single beat: out_data=0x12345678, out_bits=32, out_last=1.
5. Backpressure plus back-to-back:
   - Hold out_ready=0 for 3 cycles mid-word; out_data, out_bits and out_last must stay stable.
   - Present the next word during the last handshake; it is accepted that cycle and its first beat appears the next cycle.
6. Reset mid-word: assert clr asynchronously during beat 2 of case 1.
   - out_valid drops immediately and all outputs go to 0.
   - After release, load_ready=1 and no stale beats are emitted.

Source files
------------

// File: rtl/var_shift_pkg.sv
// Shared definitions for the variable shift-in / unshift-out register pair.
package var_shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 6;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Chunk size 0 or anything wider than the word means "whole word in one beat".
    function automatic logic [15:0] clamp_shift(input logic [15:0] s, input int w);
        logic [15:0] wv;
        wv = 16'(w);
        if (s == 16'd0 || s > wv)
            return wv;
        return s;
    endfunction

endpackage

// File: rtl/var_chunk_sel.sv
// Picks the current k-bit chunk out of the shift register, right-justified.
module var_chunk_sel
    import var_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic [WIDTH-1:0] sreg,
    input  logic             dir,
    input  logic [SHW-1:0]   k,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] right_chunk;
    logic [WIDTH-1:0] left_chunk;
    logic [SHW-1:0]   left_amt;

    // Right shift takes the low k bits; left shift brings the top k bits down.
    // Shift amounts equal to WIDTH yield zero, which covers k=0 and k=WIDTH cleanly.
    always_comb begin
        mask        = ~({WIDTH{1'b1}} << k);
        right_chunk = sreg & mask;
        left_amt    = SHW'(WIDTH) - k;
        left_chunk  = sreg >> left_amt;
        data        = (dir == DIR_LEFT) ? left_chunk : right_chunk;
    end

endmodule

// File: rtl/var_unshift_tx.sv
// Serialises a parallel word into variable-width chunks over a valid/ready stream.
module var_unshift_tx
    import var_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    input  logic [SHW-1:0]   load_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_bits,
    output logic             out_last
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             dreg;
    logic [SHW-1:0]   nreg;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   k;
    logic [WIDTH-1:0] chunk;
    logic             send;
    logic             last_beat;
    logic             beat_fire;
    logic             load_fire;

    var_chunk_sel #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_chunk_sel (
        .sreg (sreg),
        .dir  (dreg),
        .k    (k),
        .data (chunk)
    );

    // Beat size, handshakes and outputs all derive from registered state, so a
    // stalled beat holds steady; load_ready opens early on the final handshake.
    always_comb begin
        send       = (state == SEND);
        k          = (nreg < rem) ? nreg : rem;
        last_beat  = send && (rem == k);
        beat_fire  = send && out_ready;
        load_ready = !clr && ((state == IDLE) || (beat_fire && last_beat));
        load_fire  = load_valid && load_ready;
        out_valid  = send;
        out_last   = last_beat;
        out_bits   = send ? k : '0;
        out_data   = send ? chunk : '0;
    end

    // Next state: a load alongside the last handshake keeps us in SEND with no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_fire) state_nxt = SEND;
            SEND: if (beat_fire && last_beat) state_nxt = load_fire ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Word capture on load; consume k bits per accepted beat with zero fill.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sreg <= '0;
            dreg <= 1'b0;
            nreg <= '0;
            rem  <= '0;
        end else if (load_fire) begin
            sreg <= load_data;
            dreg <= load_dir;
            nreg <= SHW'(clamp_shift(16'(load_shift), WIDTH));
            rem  <= SHW'(WIDTH);
        end else if (beat_fire) begin
            rem  <= rem - k;
            sreg <= (dreg == DIR_LEFT) ? (sreg << k) : (sreg >> k);
        end
    end

endmodule

// File: tb/tb_var_unshift_tx.sv
// Scoreboard bench for var_unshift_tx: expected beats queued at load, checked at handshake.
module tb_var_unshift_tx;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  bits;
        logic        last;
    } beat_t;

    logic        clk;
    logic        clr;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_dir;
    logic [5:0]  load_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_last;

    beat_t sb[$];
    int    n_checks;
    int    n_fail;
    int    beat_cnt;

    var_unshift_tx #(.WIDTH(32), .SHW(6)) dut (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .load_shift (load_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bits   (out_bits),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-indexed reference: beat i covers word bits [i*n .. i*n+k-1] from the LSB
    // (right) or from the MSB (left), written right-justified.
    task automatic push_model(input logic [31:0] data, input logic dir, input int shift);
        int    n;
        int    pos;
        int    kk;
        beat_t b;
        n   = (shift == 0 || shift > 32) ? 32 : shift;
        pos = 0;
        while (pos < 32) begin
            kk     = (32 - pos < n) ? (32 - pos) : n;
            b.data = '0;
            for (int j = 0; j < kk; j++) begin
                if (dir == 1'b0) b.data[j] = data[pos + j];
                else             b.data[kk - 1 - j] = data[31 - pos - j];
            end
            b.bits = 6'(kk);
            b.last = (pos + kk == 32);
            sb.push_back(b);
            pos += kk;
        end
    endtask

    // Present a word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic do_load(input logic [31:0] data, input logic dir, input int shift);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = data;
        load_dir   = dir;
        load_shift = 6'(shift);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (load_ready) begin
                push_model(data, dir, shift);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL load_accept: word %h never accepted, required acceptance within 100 cycles", data);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!out_valid && sb.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: out_valid=%0d pending=%0d, required idle with empty scoreboard", name, out_valid, sb.size());
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (!clr && out_valid && out_ready) begin
            beat_t e;
            n_checks++;
            beat_cnt++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data=%h bits=%0d last=%0d, required no beat", out_data, out_bits, out_last);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_bits !== e.bits || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h bits=%0d last=%0d, required data=%h bits=%0d last=%0d",
                             out_data, out_bits, out_last, e.data, e.bits, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        clr = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bits !== 6'd0 || out_last !== 1'b0 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0d data=%h bits=%0d last=%0d ready=%0d, required all 0",
                     out_valid, out_data, out_bits, out_last, load_ready);
        end
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%0d valid=%0d, required ready=1 valid=0", load_ready, out_valid);
        end
    endtask

    task automatic test_word(input string name, input logic [31:0] data, input logic dir,
                             input int shift, input int beats);
        out_ready = 1'b1;
        beat_cnt  = 0;
        do_load(data, dir, shift);
        wait_idle(name);
        n_checks++;
        if (beat_cnt != beats || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_count: got beats=%0d ready=%0d, required beats=%0d ready=1", name, beat_cnt, load_ready, beats);
        end
    endtask

    task automatic test_right_bytes();
        test_word("right_bytes", 32'hA1B2C3D4, 1'b0, 8, 4);
    endtask

    task automatic test_left_bytes();
        test_word("left_bytes", 32'hA1B2C3D4, 1'b1, 8, 4);
    endtask

    task automatic test_short_final();
        test_word("short_final", 32'hFFFFFFFF, 1'b0, 6, 6);
        test_word("odd_left", 32'h9E3779B9, 1'b1, 5, 7);
    endtask

    task automatic test_clamp();
        test_word("clamp_zero", 32'h12345678, 1'b0, 0, 1);
        test_word("clamp_forty", 32'h12345678, 1'b1, 40, 1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready = 1'b1;
        beat_cnt  = 0;
        do_load(32'h12345678, 1'b0, 8);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (sb.size() == 0 || out_valid !== 1'b1 || out_data !== sb[0].data || out_bits !== sb[0].bits || out_last !== sb[0].last) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%0d data=%h bits=%0d last=%0d, required valid=1 data=%h bits=%0d last=%0d",
                         out_valid, out_data, out_bits, out_last, sb[0].data, sb[0].bits, sb[0].last);
            end
        end
        @(posedge clk); #1;
        out_ready  = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hCAFEF00D;
        load_dir   = 1'b1;
        load_shift = 6'd16;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (load_ready) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_overlap: got valid=%0d last=%0d at accept, required valid=1 last=1", out_valid, out_last);
                end
                push_model(32'hCAFEF00D, 1'b1, 16);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_bubble: got accepted=%0d valid=%0d, required accepted=1 valid=1", ok, out_valid);
        end
        wait_idle("b2b");
        n_checks++;
        if (beat_cnt != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got beats=%0d, required 6", beat_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        int seen;
        out_ready = 1'b1;
        beat_cnt  = 0;
        do_load(32'hA1B2C3D4, 1'b0, 8);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bits !== 6'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clr: got valid=%0d data=%h bits=%0d last=%0d, required all 0",
                     out_valid, out_data, out_bits, out_last);
        end
        sb.delete();
        seen = beat_cnt;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_release: got ready=%0d valid=%0d, required ready=1 valid=0", load_ready, out_valid);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (beat_cnt != seen || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_beats: got %0d extra beats valid=%0d, required 0 extra valid=0", beat_cnt - seen, out_valid);
        end
        test_word("after_clr", 32'h0F0F0F0F, 1'b1, 32, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        beat_cnt   = 0;
        clr        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_dir   = 1'b0;
        load_shift = '0;
        out_ready  = 1'b0;
        test_reset();
        test_right_bytes();
        test_left_bytes();
        test_short_final();
        test_clamp();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
